// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package disp_pkg;

   typedef enum logic {GAP, SHOW} state_e;

   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [3:0] AN_OFF   = 4'hF;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low segment decoder.
// Non-BCD nibbles (A..F) show a dash on segment g.
module bcd_to_7seg
   import disp_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (nib)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_7seg_scan.sv
// 4-digit common-anode scan driver with a blanked gap at the start of each slot.
// Optional leading-zero blanking: define BCD7SEG_LZ_BLANK_EN.
module bcd_7seg_scan
   import disp_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int GAP_CYCLES  = 1000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        LOAD,
   input  logic [15:0] BCDIN,
   input  logic [3:0]  DP_IN,
   output logic [3:0]  AN,
   output logic [6:0]  SEG,
   output logic        DP
);

   localparam int CW = $clog2(REFRESH_DIV);

   logic [15:0]   val_q, val_d;
   logic [3:0]    dpl_q, dpl_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   state_e        state_q, state_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          cnt_wrap;
   logic          blank;
   logic [3:0]    nib;
   logic [6:0]    nib_seg;

   assign nib = val_q[4*idx_q +: 4];

   bcd_to_7seg u_dec (
      .nib (nib),
      .seg (nib_seg)
   );

   always_comb begin
      val_d    = LOAD ? BCDIN : val_q;
      dpl_d    = LOAD ? DP_IN : dpl_q;
      cnt_wrap = (cnt_q == CW'(REFRESH_DIV - 1));
      cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
      idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;

      state_d = state_q;
      case (state_q)
         GAP:  if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = SHOW;
         SHOW: if (cnt_wrap) state_d = GAP;
         default: state_d = GAP;
      endcase

`ifdef BCD7SEG_LZ_BLANK_EN
      // A digit is leading only if every more significant digit is zero too.
      case (idx_q)
         2'd3:    blank = (val_q[15:12] == 4'd0);
         2'd2:    blank = (val_q[15:8]  == 8'd0);
         2'd1:    blank = (val_q[15:4]  == 12'd0);
         default: blank = 1'b0;
      endcase
`else
      blank = 1'b0;
`endif

      // Outputs follow the current state, so they lag cnt/state by one cycle.
      if (state_q == SHOW && !blank) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = nib_seg;
         dp_d  = ~dpl_q[idx_q];
      end else begin
         an_d  = AN_OFF;
         seg_d = SEG_OFF;
         dp_d  = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         val_q   <= '0;
         dpl_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         state_q <= GAP;
         an_q    <= AN_OFF;
         seg_q   <= SEG_OFF;
         dp_q    <= 1'b1;
      end else begin
         val_q   <= val_d;
         dpl_q   <= dpl_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign AN  = an_q;
   assign SEG = seg_q;
   assign DP  = dp_q;

endmodule
